byte_unstriping_lanes: RTL and testbench
========================================

# byte_unstriping_lanes

Parametrised multi-lane byte unstriper and gearbox. It collects byte-striped symbol beats from up to LANES physical lanes, restores byte order with lane 0 first, and packs the byte stream into 8-, 16- or 32-bit words. Words leave through a valid/ready output FIFO. The block sits between the per-lane descramblers and the link-layer word assembler, and is the multi-lane, back-pressured successor of the single-lane unstriper.

## Interface
Parameters:
- LANES, 4: physical lane count; power of two, 1..8.
- FIFO_DEPTH, 4: output FIFO depth in words; power of two, ≥2.

Ports:
- clk8  in  1  byte-symbol clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- enb  in  1  input-side enable; low freezes buffer, config and FIFO push.
- lane_data  in  LANES*8  lane i byte at [8i+7:8i].
- in_valid  in  1  beat present on lane_data.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- lane_cnt  in  2  active lanes k: 00=x1, 01=x2, 10=x4, 11=x8.
- S  in  2  word size w: 00/11=1 byte, 01=2 bytes, 10=4 bytes.
- out_data  out  32  word; first-received byte in the MSB of the word; unused upper bytes zero.
- out_size  out  2  S encoding of out_data (00, 01, 10 only).
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  pop when out_valid & out_ready.
- cfg_err  out  1  sticky; set when a sampled lane_cnt exceeds LANES.

## Operation
- Buffer: BUF_BYTES = max(LANES,4) byte slots and a count register cnt (0..BUF_BYTES).
- Config:
  - Effective (k,w) = live inputs when cnt==0, else latched values.
  - Latch updates on every enabled cycle with cnt==0.
  - A mid-word change of S or lane_cnt is deferred to the next empty-buffer point; the word in progress is never mixed.
- Clamp: if lane_cnt decodes to more than LANES, k=LANES and cfg_err sets. cfg_err clears only on reset.
- Push: when enb, cnt≥w and FIFO not full:
  - The oldest w bytes form a word, oldest byte in bits [8w-1:8w-8], and are written to the FIFO with out_size = the latched S (00 for S=11).
  - The buffer shifts down by w.
- Accept:
  - in_ready = enb & (cnt − (push ? w : 0) + k ≤ BUF_BYTES).
  - An accepted beat appends lanes 0..k−1 in that order after the remaining bytes; lanes ≥k are ignored.
  - Push and accept may occur in the same cycle.
- Gearbox behaviour:
  - k<w: w/k beats per word.
  - k=w: one word per beat, full throughput.
  - k>w: one beat yields k/w words, emitted at one per cycle; in_ready stays low until the buffer has room for another beat.
- Pop: out_valid & out_ready removes the head word. Pop is independent of enb.
- FIFO full: push stalls, cnt holds, and in_ready falls once the buffer cannot take k more bytes. No data is ever dropped.

## Timing
- Reset values: cnt=0; buffer zero; FIFO empty; out_valid=0; out_data=0; out_size=00; cfg_err=0; latched cfg k=1, w=1; in_ready=0 during reset.
- Latency:
  - Completing beat accepted at edge t → word pushed at edge t+1 → out_valid high after edge t+1.
  - Minimum latency is 2 cycles from beat presentation to out_valid.
- in_ready is combinational from cnt, FIFO full, enb and the effective config. out_data/out_size/out_valid are registered.
- Simultaneous push and pop on a full FIFO are both allowed.
- Reset mid-word discards partial bytes and all FIFO contents on that edge.
- enb low mid-word: cnt and bytes hold; accumulation resumes unchanged when enb returns.

## Structure
- Shared package byte_unstriping_pkg holds:
  - S encodings and lane_cnt encodings;
  - function bytes_of_mode(S) → 1/2/4;
  - function lanes_of_cnt(lane_cnt) → 1/2/4/8.
- One sub-module: unstripe_fifo, a synchronous FIFO of FIFO_DEPTH × 34 bits ({out_size, out_data}) with full/empty flags, registered output, and simultaneous push/pop.
- Gearbox buffer, config latch and handshake logic stay in the top module.

## Test plan
- LANES=4, k=x1, S=10:
  - Stimulus: bytes 11,22,33,44 on lane 0 over 4 beats, out_ready=1.
  - Response: one word 11223344, out_size=10, out_valid 2 cycles after the 4th beat.
- k=x4, S=00:
  - Stimulus: one beat lanes0..3 = A0,A1,A2,A3.
  - Response: words 000000A0, 000000A1, 000000A2, 000000A3 on consecutive cycles; in_ready low for 3 cycles.
- k=x2, S=01, streaming 8 beats:
  - Response: 8 words, one per cycle after the first, in_ready constantly high.
- Back-pressure:
  - Stimulus: k=x4, S=10, out_ready=0, FIFO_DEPTH=4, in_valid held high.
  - Response: exactly 4 words stored plus one beat buffered, then in_ready=0.
  - Then raise out_ready: all words drain in order with none lost.
- Mid-word change and lane clamp:
  - Stimulus: S switched to 00 after 1 of 2 bytes in S=01.
  - Response: the 16-bit word completes first, then 8-bit words follow.
  - Stimulus: lane_cnt=11 with LANES=4.
  - Response: cfg_err=1, k behaves as x4.
- Reset and enable:
  - Stimulus: reset asserted with cnt=3 and FIFO=2.
  - Response: next cycle out_valid=0 and cnt=0; the partial word is never emitted.
  - Stimulus: enb=0 for 5 cycles mid-word.
  - Response: word contents are identical to the enb=1 case.

Source files
------------

// File: rtl/byte_unstriping_pkg.sv
// Shared encodings and decode helpers for the multi-lane byte unstriper.
package byte_unstriping_pkg;

    typedef enum logic [1:0] {
        SZ_8     = 2'b00,
        SZ_16    = 2'b01,
        SZ_32    = 2'b10,
        SZ_8_ALT = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        LN_X1 = 2'b00,
        LN_X2 = 2'b01,
        LN_X4 = 2'b10,
        LN_X8 = 2'b11
    } lane_e;

    localparam int WORD_W  = 32;
    localparam int ENTRY_W = WORD_W + 2;

    function automatic logic [2:0] bytes_of_mode(input logic [1:0] s);
        case (size_e'(s))
            SZ_16:   return 3'd2;
            SZ_32:   return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [3:0] lanes_of_cnt(input logic [1:0] c);
        return 4'd1 << c;
    endfunction

    // The spare 11 encoding is reported downstream as the plain byte size.
    function automatic logic [1:0] size_code(input logic [1:0] s);
        return (size_e'(s) == SZ_8_ALT) ? 2'b00 : s;
    endfunction

endpackage

// File: rtl/unstripe_fifo.sv
// Word FIFO with registered head output; push and pop may coincide, even when full.
module unstripe_fifo
    import byte_unstriping_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ENTRY_W
) (
    input  logic         clk8,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [AW:0]   count, count_next, left;
    logic          do_push, do_pop;

    assign full = (count == (AW+1)'(DEPTH));

    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        rd_next    = rd_ptr + AW'(do_pop);
        left       = count - (AW+1)'(do_pop);
        count_next = left + (AW+1)'(do_push);
    end

    always_ff @(posedge clk8) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // The head register follows the entry that will sit at rd_next after this edge.
    always_ff @(posedge clk8) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            rdata  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_next;
            count  <= count_next;
            empty  <= (count_next == '0);
            if (count_next == '0)
                rdata <= '0;
            else if (do_push && left == '0)
                rdata <= wdata;
            else
                rdata <= mem[rd_next];
        end
    end

endmodule

// File: rtl/byte_unstriping_lanes.sv
// Multi-lane byte unstriper and 8/16/32-bit gearbox feeding a valid/ready word FIFO.
module byte_unstriping_lanes
    import byte_unstriping_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk8,
    input  logic               reset,
    input  logic               enb,
    input  logic [LANES*8-1:0] lane_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         lane_cnt,
    input  logic [1:0]         S,
    output logic [31:0]        out_data,
    output logic [1:0]         out_size,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               cfg_err
);
    localparam int BUF_BYTES = (LANES > 4) ? LANES : 4;
    localparam int CW        = $clog2(BUF_BYTES + 1);
    localparam int IW        = $clog2(BUF_BYTES);

    logic [BUF_BYTES-1:0][7:0] byte_buf, buf_d;
    logic [CW-1:0]             cnt, cnt_d;
    logic [3:0]                lat_k, live_k, eff_k;
    logic [2:0]                lat_w, live_w, eff_w;
    logic [1:0]                lat_size;
    logic                      live_over, push, accept;
    logic                      fifo_full, fifo_empty;
    logic [31:0]               word;
    logic [ENTRY_W-1:0]        fifo_rdata;
    int                        shift, rem;

    // Live config only steers an empty buffer, so a word in flight never mixes sizes.
    always_comb begin
        live_over = lanes_of_cnt(lane_cnt) > 4'(LANES);
        live_k    = live_over ? 4'(LANES) : lanes_of_cnt(lane_cnt);
        live_w    = bytes_of_mode(S);
        eff_k     = (cnt == '0) ? live_k : lat_k;
        eff_w     = (cnt == '0) ? live_w : lat_w;
    end

    always_comb begin
        push     = enb && (int'(cnt) >= int'(eff_w)) && !fifo_full;
        shift    = push ? int'(lat_w) : 0;
        rem      = int'(cnt) - shift;
        in_ready = !reset && enb && (rem + int'(eff_k) <= BUF_BYTES);
        accept   = in_valid && in_ready;
    end

    // Oldest byte lands in the most significant byte of the active width.
    always_comb begin
        case (lat_w)
            3'd4:    word = {byte_buf[0], byte_buf[1], byte_buf[2], byte_buf[3]};
            3'd2:    word = {16'h0, byte_buf[0], byte_buf[1]};
            default: word = {24'h0, byte_buf[0]};
        endcase
    end

    always_comb begin
        buf_d = '0;
        for (int i = 0; i < BUF_BYTES; i++) begin
            if (i + shift < BUF_BYTES)
                buf_d[i] = byte_buf[IW'(i + shift)];
        end
        for (int j = 0; j < LANES; j++) begin
            if (accept && j < int'(eff_k))
                buf_d[IW'(rem + j)] = lane_data[8*j +: 8];
        end
        cnt_d = CW'(rem + (accept ? int'(eff_k) : 0));
    end

    always_ff @(posedge clk8) begin
        if (reset) begin
            byte_buf <= '0;
            cnt      <= '0;
            lat_k    <= 4'd1;
            lat_w    <= 3'd1;
            lat_size <= 2'b00;
            cfg_err  <= 1'b0;
        end else begin
            byte_buf <= buf_d;
            cnt      <= cnt_d;
            if (enb && cnt == '0) begin
                lat_k    <= live_k;
                lat_w    <= live_w;
                lat_size <= size_code(S);
                if (live_over) cfg_err <= 1'b1;
            end
        end
    end

    unstripe_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk8  (clk8),
        .reset (reset),
        .push  (push),
        .wdata ({lat_size, word}),
        .pop   (out_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_size  = fifo_rdata[ENTRY_W-1 -: 2];
    assign out_data  = fifo_rdata[WORD_W-1:0];

endmodule

// File: tb/tb_byte_unstriping_lanes.sv
// Directed bench for byte_unstriping_lanes (LANES=4, FIFO_DEPTH=4) with immediate-assert checks.
module tb_byte_unstriping_lanes;
    logic        clk8 = 1'b0;
    logic        reset, enb, in_valid, in_ready, out_valid, out_ready, cfg_err;
    logic [31:0] lane_data, out_data;
    logic [1:0]  lane_cnt, S, out_size;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
        int          c;
    } rec_t;
    rec_t q[$];

    byte_unstriping_lanes #(.LANES(4), .FIFO_DEPTH(4)) dut (
        .clk8      (clk8),
        .reset     (reset),
        .enb       (enb),
        .lane_data (lane_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lane_cnt  (lane_cnt),
        .S         (S),
        .out_data  (out_data),
        .out_size  (out_size),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_err   (cfg_err)
    );

    always #5 clk8 = ~clk8;
    always @(posedge clk8) cyc_n <= cyc_n + 1;

    // Words are logged at the falling edge ahead of the rising edge that pops them.
    always @(negedge clk8) begin
        if (out_valid && out_ready) q.push_back('{out_data, out_size, cyc_n});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk8);
        #2;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cyc();
    endtask

    // Presents a beat and returns just after the edge that accepts it.
    task automatic send(input logic [31:0] d, output int waited);
        lane_data = d;
        in_valid  = 1'b1;
        #1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            cyc();
            waited++;
        end
        if (waited >= 50) chk("send_timeout", 64'(waited), 64'd0);
        cyc();
    endtask

    task automatic chk_word(input string tag, input int i, input logic [31:0] d, input logic [1:0] s);
        if (i < q.size()) begin
            chk({tag, "_data"}, 64'(q[i].d), 64'(d));
            chk({tag, "_size"}, 64'(q[i].s), 64'(s));
        end else begin
            chk({tag, "_count"}, 64'(q.size()), 64'(i + 1));
        end
    endtask

    function automatic logic [31:0] bp_beat(input int n);
        logic [7:0] b;
        b = 8'(16 * (n + 1));
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic logic [31:0] bp_word(input int n);
        logic [7:0] b;
        b = 8'(16 * (n + 1));
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, waits, n;
        logic acc;

        reset = 1'b1; enb = 1'b1; in_valid = 1'b0; lane_data = '0;
        lane_cnt = 2'b00; S = 2'b00; out_ready = 1'b0;
        cyc();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        cyc();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_size", 64'(out_size), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        reset = 1'b0;
        cyc();
        chk("rst_cnt", 64'(dut.cnt), 64'd0);

        // x1 lanes into 32-bit words, latency check
        q.delete(); out_ready = 1'b1; lane_cnt = 2'b00; S = 2'b10;
        send(32'h11, w); send(32'h22, w); send(32'h33, w); send(32'h44, w);
        in_valid = 1'b0;
        chk("x1_lat_t", 64'(out_valid), 64'd0);
        cyc();
        chk("x1_lat_t1", 64'(out_valid), 64'd1);
        chk("x1_head_data", 64'(out_data), 64'h11223344);
        chk("x1_head_size", 64'(out_size), 64'd2);
        idle(3);
        chk("x1_nwords", 64'(q.size()), 64'd1);

        // x4 lanes into bytes: one beat fans out to four words
        q.delete(); lane_cnt = 2'b10; S = 2'b00;
        send(32'hA3A2A1A0, w);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("x4b_rdy_low", 64'(in_ready), 64'd0);
            cyc();
        end
        chk("x4b_rdy_high", 64'(in_ready), 64'd1);
        idle(4);
        chk("x4b_nwords", 64'(q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk_word("x4b_word", i, 32'hA0 + 32'(i), 2'b00);
            if (i < q.size()) chk("x4b_spacing", 64'(q[i].c - q[0].c), 64'(i));
        end

        // x2 lanes into 16-bit words, streaming at full rate
        q.delete(); lane_cnt = 2'b01; S = 2'b01; waits = 0;
        for (int i = 0; i < 8; i++) begin
            send({16'h0, 8'(8'h11 + 2 * i), 8'(8'h10 + 2 * i)}, w);
            waits += w;
        end
        in_valid = 1'b0;
        chk("x2_no_stall", 64'(waits), 64'd0);
        idle(4);
        chk("x2_nwords", 64'(q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk_word("x2_word", i, {16'h0, 8'(8'h10 + 2 * i), 8'(8'h11 + 2 * i)}, 2'b01);
            if (i < q.size()) chk("x2_spacing", 64'(q[i].c - q[0].c), 64'(i));
        end

        // back-pressure: FIFO fills, one more beat parks in the buffer
        q.delete(); out_ready = 1'b0; lane_cnt = 2'b10; S = 2'b10; n = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            lane_data = bp_beat(n);
            #1;
            acc = in_ready;
            cyc();
            if (acc) n++;
        end
        chk("bp_beats", 64'(n), 64'd5);
        chk("bp_rdy_low", 64'(in_ready), 64'd0);
        chk("bp_head", 64'(out_data), 64'(bp_word(0)));
        in_valid = 1'b0; out_ready = 1'b1;
        idle(10);
        chk("bp_nwords", 64'(q.size()), 64'd5);
        for (int i = 0; i < 5; i++) chk_word("bp_word", i, bp_word(i), 2'b10);

        // size change mid-word waits for the buffer to empty
        q.delete(); lane_cnt = 2'b00; S = 2'b01;
        send(32'hC1, w);
        S = 2'b00;
        send(32'hC2, w);
        idle(1);
        send(32'hC3, w); send(32'hC4, w);
        idle(4);
        chk("mid_nwords", 64'(q.size()), 64'd3);
        chk_word("mid_w0", 0, 32'h0000C1C2, 2'b01);
        chk_word("mid_w1", 1, 32'h000000C3, 2'b00);
        chk_word("mid_w2", 2, 32'h000000C4, 2'b00);

        // x8 request on a 4-lane build clamps to x4 and flags cfg_err
        chk("clamp_err_pre", 64'(cfg_err), 64'd0);
        q.delete(); lane_cnt = 2'b11; S = 2'b10;
        send(32'hD3D2D1D0, w);
        in_valid = 1'b0;
        chk("clamp_err", 64'(cfg_err), 64'd1);
        idle(4);
        chk("clamp_nwords", 64'(q.size()), 64'd1);
        chk_word("clamp_word", 0, 32'hD0D1D2D3, 2'b10);

        // reset with a partial word and two queued words
        q.delete(); out_ready = 1'b0; lane_cnt = 2'b00; S = 2'b10;
        for (int i = 0; i < 11; i++) send(32'(i + 1), w);
        in_valid = 1'b0;
        chk("rmid_cnt_pre", 64'(dut.cnt), 64'd3);
        chk("rmid_valid_pre", 64'(out_valid), 64'd1);
        reset = 1'b1;
        cyc();
        chk("rmid_out_valid", 64'(out_valid), 64'd0);
        chk("rmid_cnt", 64'(dut.cnt), 64'd0);
        chk("rmid_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        chk("rmid_cfg_err", 64'(cfg_err), 64'd0);
        out_ready = 1'b1;
        idle(3);
        chk("rmid_no_words", 64'(q.size()), 64'd0);
        send(32'hE1, w); send(32'hE2, w); send(32'hE3, w); send(32'hE4, w);
        idle(4);
        chk("rmid_nwords", 64'(q.size()), 64'd1);
        chk_word("rmid_word", 0, 32'hE1E2E3E4, 2'b10);

        // enable low mid-word freezes accumulation
        q.delete();
        send(32'hF1, w); send(32'hF2, w);
        enb = 1'b0; lane_data = 32'h5A; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("enb_rdy_low", 64'(in_ready), 64'd0);
            cyc();
        end
        chk("enb_no_word", 64'(out_valid), 64'd0);
        enb = 1'b1;
        send(32'hF3, w); send(32'hF4, w);
        idle(4);
        chk("enb_nwords", 64'(q.size()), 64'd1);
        chk_word("enb_word", 0, 32'hF1F2F3F4, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
